// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO: programmable baud divisor, 5..DATA_W data bits,
// optional even/odd parity and one or two stop bits; frames are sent back-to-back.
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BRR_W      = 16
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          En,
  input  logic [BRR_W-1:0]              Brr,
  input  logic [3:0]                    Nbits,
  input  logic [1:0]                    Parity,
  input  logic                          Stop2,
  input  logic [DATA_W-1:0]             S_tdata,
  input  logic                          S_tvalid,
  output logic                          S_tready,
  output logic                          Tx,
  output logic                          Busy,
  output logic                          Txe,
  output logic [$clog2(FIFO_DEPTH):0]   Level,
  output logic                          Tc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  state_e            state_q, state_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              tc_q, tc_d;
  logic [BRR_W-1:0]  baud_q, baud_d;
  logic [BRR_W-1:0]  brr_q, brr_d;
  logic [3:0]        bit_q, bit_d;
  logic [3:0]        nbits_q, nbits_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic [DATA_W-1:0] shift_q, shift_d;

  logic [3:0]        nb_eff;
  logic [BRR_W-1:0]  brr_m1;
  logic              head_par;
  logic              start;

  assign S_tready = (count_q != LW'(FIFO_DEPTH));
  assign Txe      = (count_q == '0);
  assign Level    = count_q;
  assign Tx       = tx_q;
  assign Busy     = busy_q;
  assign Tc       = tc_q;

  assign push = S_tvalid && S_tready;
  assign head = mem[rd_ptr_q];

  always_comb begin
    if (Nbits < 4'd5)               nb_eff = 4'd5;
    else if (Nbits > 4'(DATA_W))    nb_eff = 4'(DATA_W);
    else                            nb_eff = Nbits;
  end

  assign brr_m1 = (Brr < BRR_W'(2)) ? BRR_W'(1) : Brr - BRR_W'(1);

  // Parity covers only the bits actually sent, so it is taken on the clamped length.
  always_comb begin
    head_par = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (4'(i) < nb_eff) head_par = head_par ^ head[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    tc_d      = 1'b0;
    baud_d    = baud_q;
    brr_d     = brr_q;
    bit_d     = bit_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    shift_d   = shift_q;
    start     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (En && !Txe) start = 1'b1;
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          baud_d  = brr_q;
        end else begin
          baud_d = baud_q - BRR_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = brr_q;
          if (bit_q == nbits_q - 4'd1) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q - BRR_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_q == '0) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
          baud_d  = brr_q;
        end else begin
          baud_d = baud_q - BRR_W'(1);
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_d  = 4'd1;
            baud_d = brr_q;
          end else begin
            tc_d = 1'b1;
            if (En && !Txe) begin
              start = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end
        end else begin
          baud_d = baud_q - BRR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start is shared by IDLE and end-of-STOP so back-to-back frames need no gap.
    if (start) begin
      state_d   = S_START;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      baud_d    = brr_m1;
      brr_d     = brr_m1;
      nbits_d   = nb_eff;
      par_en_d  = (Parity == 2'b01) || (Parity == 2'b10);
      par_bit_d = head_par ^ (Parity == 2'b10);
      stop2_d   = Stop2;
      shift_d   = head;
    end
  end

  assign pop = start;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= S_tdata;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tc_q      <= 1'b0;
      baud_q    <= '0;
      brr_q     <= '0;
      bit_q     <= '0;
      nbits_q   <= 4'd5;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      shift_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tc_q      <= tc_d;
      baud_q    <= baud_d;
      brr_q     <= brr_d;
      bit_q     <= bit_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed pushes queue expected line waveforms; a negedge
// monitor checks each frame cycle by cycle plus the Tc pulse that follows it.
module tb_uart_tx_fifo;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        En;
  logic [15:0] Brr;
  logic [3:0]  Nbits;
  logic [1:0]  Parity;
  logic        Stop2;
  logic [8:0]  S_tdata;
  logic        S_tvalid;
  logic        S_tready;
  logic        Tx;
  logic        Busy;
  logic        Txe;
  logic [4:0]  Level;
  logic        Tc;

  uart_tx_fifo #(.DATA_W(9), .FIFO_DEPTH(16), .BRR_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Brr(Brr), .Nbits(Nbits), .Parity(Parity),
    .Stop2(Stop2), .S_tdata(S_tdata), .S_tvalid(S_tvalid), .S_tready(S_tready),
    .Tx(Tx), .Busy(Busy), .Txe(Txe), .Level(Level), .Tc(Tc)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [12:0] lv;
    logic [8:0]  word;
    int unsigned nlv;
    int unsigned b;
  } frame_t;

  frame_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line levels: start, nb data bits LSB first, optional parity, stop bit(s).
  function automatic frame_t mk_frame(input logic [8:0] w, input int unsigned nb,
                                      input int unsigned b, input logic [1:0] par,
                                      input logic st2);
    frame_t f;
    int unsigned k;
    logic p;
    f.lv = '1;
    f.word = w;
    f.b = b;
    f.lv[0] = 1'b0;
    p = 1'b0;
    for (int unsigned i = 0; i < nb; i++) begin
      f.lv[1+i] = w[i];
      p = p ^ w[i];
    end
    k = 1 + nb;
    if (par == 2'b01) begin f.lv[k] = p;  k++; end
    else if (par == 2'b10) begin f.lv[k] = ~p; k++; end
    f.lv[k] = 1'b1; k++;
    if (st2) begin f.lv[k] = 1'b1; k++; end
    f.nlv = k;
    return f;
  endfunction

  // Monitor
  frame_t      cur;
  bit          mon_act = 1'b0;
  bit          tc_pend = 1'b0;
  int unsigned cyc;
  int unsigned ferr;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      mon_act = 1'b0;
      tc_pend = 1'b0;
      sb.delete();
    end else begin
      if (tc_pend) begin
        check("tc_after_frame", Tc, 1);
        tc_pend = 1'b0;
      end else if (Tc) begin
        check("tc_spurious", Tc, 0);
      end
      if (!mon_act && Tx === 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_start", sb.size(), 1);
        end else begin
          cur = sb.pop_front();
          mon_act = 1'b1;
          cyc = 0;
          ferr = 0;
        end
      end
      if (mon_act) begin
        if (Tx !== cur.lv[cyc / cur.b]) ferr++;
        cyc++;
        if (cyc == cur.nlv * cur.b) begin
          n_cmp++;
          if (ferr != 0) begin
            n_fail++;
            $display("FAIL frame word=%0h: got %0d bad line cycles expected 0", cur.word, ferr);
          end
          mon_act = 1'b0;
          tc_pend = 1'b1;
        end
      end
    end
  end

  // Called at a negedge; drives one push for a cycle and returns at the next negedge.
  task automatic push(input logic [8:0] w, input frame_t f, output bit acc);
    S_tdata = w;
    S_tvalid = 1'b1;
    acc = S_tready;
    if (acc) sb.push_back(f);
    @(negedge Clk);
    S_tvalid = 1'b0;
  endtask

  task automatic run_to_tc(output int n);
    n = 0;
    while (!Tc && n < 1000) begin
      n++;
      @(negedge Clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n, tcs, nacc, errs;

    Rst_n = 1'b0; En = 1'b1; Brr = 16'd4; Nbits = 4'd8; Parity = 2'b00; Stop2 = 1'b0;
    S_tdata = 9'h1AB; S_tvalid = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_tx", Tx, 1);
    check("rst_tready", S_tready, 1);
    check("rst_level", Level, 0);
    check("rst_busy", Busy, 0);
    check("rst_tc", Tc, 0);
    check("rst_txe", Txe, 1);
    S_tvalid = 1'b0;
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_no_push", Level, 0);

    // 8N1, Brr=4, 0x55
    push(9'h055, mk_frame(9'h055, 8, 4, 2'b00, 1'b0), acc);
    check("8n1_acc", acc, 1);
    check("8n1_idle_k", Tx, 1);
    check("8n1_level_k", Level, 1);
    @(negedge Clk);
    check("8n1_start_tx", Tx, 0);
    check("8n1_start_busy", Busy, 1);
    check("8n1_popped", Level, 0);
    run_to_tc(n);
    check("8n1_len", n, 40);
    check("8n1_busy_fall", Busy, 0);
    @(negedge Clk);
    check("8n1_tc_single", Tc, 0);

    // Parity variants, Brr=3, 0x07
    Brr = 16'd3; Parity = 2'b01; Stop2 = 1'b0;
    push(9'h007, mk_frame(9'h007, 8, 3, 2'b01, 1'b0), acc);
    @(negedge Clk);
    run_to_tc(n);
    check("even_len", n, 33);
    @(negedge Clk);
    Parity = 2'b10;
    push(9'h007, mk_frame(9'h007, 8, 3, 2'b10, 1'b0), acc);
    @(negedge Clk);
    run_to_tc(n);
    check("odd_len", n, 33);
    @(negedge Clk);
    Parity = 2'b01; Stop2 = 1'b1;
    push(9'h007, mk_frame(9'h007, 8, 3, 2'b01, 1'b1), acc);
    @(negedge Clk);
    run_to_tc(n);
    check("stop2_len", n, 36);
    check("stop2_busy", Busy, 0);
    @(negedge Clk);

    // Clamping and mid-frame config change
    Brr = 16'd0; Nbits = 4'd3; Parity = 2'b00; Stop2 = 1'b0;
    push(9'h1FF, mk_frame(9'h1FF, 5, 2, 2'b00, 1'b0), acc);
    push(9'h0A5, mk_frame(9'h0A5, 8, 2, 2'b00, 1'b0), acc);
    check("clamp_pushpop_level", Level, 1);
    check("clamp_start", Tx, 0);
    n = 0;
    while (!Tc && n < 200) begin
      n++;
      if (n == 4) Nbits = 4'd8;
      @(negedge Clk);
    end
    check("clamp_len", n, 14);
    check("b2b_start", Tx, 0);
    check("b2b_busy", Busy, 1);
    n = 0;
    do begin
      n++;
      @(negedge Clk);
    end while (!Tc && n < 200);
    check("next_8bit_len", n, 20);
    check("next_busy_fall", Busy, 0);
    @(negedge Clk);

    // FIFO full, then burst
    En = 1'b0; Brr = 16'd2; Nbits = 4'd8; Parity = 2'b00; Stop2 = 1'b0;
    nacc = 0;
    for (int i = 0; i < 17; i++) begin
      push(9'(i), mk_frame(9'(i), 8, 2, 2'b00, 1'b0), acc);
      if (acc) nacc++;
    end
    check("full_accepted", nacc, 16);
    check("full_tready", S_tready, 0);
    check("full_level", Level, 16);
    check("full_txe", Txe, 0);
    check("full_idle", Busy, 0);
    En = 1'b1;
    @(negedge Clk);
    check("burst_busy", Busy, 1);
    n = 0; tcs = 0;
    while (Busy && n < 1000) begin
      n++;
      @(negedge Clk);
      if (Tc) tcs++;
    end
    check("burst_busy_cycles", n, 320);
    check("burst_tc_count", tcs, 16);
    check("burst_txe", Txe, 1);
    check("burst_level", Level, 0);
    @(negedge Clk);

    // Abort mid-frame with three words queued
    Brr = 16'd4;
    push(9'h000, mk_frame(9'h000, 8, 4, 2'b00, 1'b0), acc);
    push(9'h011, mk_frame(9'h011, 8, 4, 2'b00, 1'b0), acc);
    push(9'h022, mk_frame(9'h022, 8, 4, 2'b00, 1'b0), acc);
    push(9'h033, mk_frame(9'h033, 8, 4, 2'b00, 1'b0), acc);
    repeat (3) @(negedge Clk);
    check("abort_pre_tx", Tx, 0);
    check("abort_pre_level", Level, 3);
    #2 Rst_n = 1'b0;
    #1;
    check("abort_tx", Tx, 1);
    check("abort_busy", Busy, 0);
    check("abort_level", Level, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (Tx !== 1'b1 || Busy !== 1'b0) errs++;
    end
    check("abort_stays_idle", errs, 0);
    check("abort_level_after", Level, 0);

    check("sb_drained", sb.size(), 0);
    check("monitor_idle", mon_act, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, programmable baud divisor and runtime-selectable frame format (data length, parity, stop bits). It is the next-generation TX path of the AES_UART peripheral: the AXI-Lite register block drives the configuration inputs (CR1, BRR) and pushes TDR writes into the stream port, and the block serialises words onto `Tx`. Unlike the single-register TX, it buffers up to `FIFO_DEPTH` words and sends frames back-to-back.

## Interface
- `DATA_W`, 9: maximum data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥2.
- `BRR_W`, 16: width of the baud divisor.
- `Clk`  in  1  system clock.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `En`  in  1  transmitter enable (CR1).
- `Brr`  in  BRR_W  clocks per bit; values 0 and 1 are treated as 2.
- `Nbits`  in  4  data bits per frame; <5 is treated as 5, >DATA_W is treated as DATA_W.
- `Parity`  in  2  00 none, 01 even, 10 odd, 11 none.
- `Stop2`  in  1  0: one stop bit, 1: two stop bits.
- `S_tdata`  in  DATA_W  word to send, LSB first; bits at and above `Nbits` are ignored.
- `S_tvalid`  in  1  push request.
- `S_tready`  out  1  FIFO not full.
- `Tx`  out  1  serial line, idle high.
- `Busy`  out  1  FSM not IDLE.
- `Txe`  out  1  FIFO empty.
- `Level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `Tc`  out  1  one-cycle pulse at the end of every frame.

## Operation
- Reset (async assert, sync release): FIFO cleared; FSM IDLE.
  - Output reset values: `Tx`=1, `S_tready`=1, `Busy`=0, `Txe`=1, `Level`=0, `Tc`=0.
  - Reset asserted mid-frame aborts the frame: `Tx` goes high immediately and buffered words are lost.
- Push: a word is written on any edge where `S_tvalid && S_tready`. `S_tready = (Level != FIFO_DEPTH)`, independent of `En`.
- Pop: occurs on the edge where the FSM leaves IDLE or STOP to start a new frame.
- Simultaneous push and pop: both take effect and `Level` is unchanged. A push while full is not possible because `S_tready`=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when `En && !Txe`. On that edge the head word is popped and `Brr`, `Nbits`, `Parity` and `Stop2` are latched.
  - START -> DATA after one bit period.
  - DATA -> PARITY (if parity is enabled) or STOP, after `Nbits` bit periods.
  - PARITY -> STOP after one bit period.
  - STOP lasts 1 or 2 bit periods, then:
    - -> START (with a new pop) if `En && !Txe`;
    - otherwise -> IDLE.
- Line levels: START drives 0. DATA drives `word[i]`, i = 0..Nbits-1. PARITY drives even = XOR of the sent data bits, odd = its inverse. STOP drives 1.
- Configuration changes take effect only at the next frame start; the latched copy governs the frame in flight.
- `En` deasserted mid-frame: the current frame completes and no further frame starts. The FIFO keeps its contents.

## Timing
- All outputs are registered except `S_tready`, `Txe` and `Level`, which decode from the FIFO count register.
- Start latency: a word pushed into an empty FIFO on edge k, with the FSM in IDLE and `En`=1, gives `Tx`=0 after edge k+1.
- Bit period: each bit lasts exactly B = max(`Brr`,2) cycles. A down-counter is loaded with B-1 and a bit advances when it reaches 0.
- Frame length: B*(1+Nbits+P+S) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle, with zero idle gap.
- `Tc` is high for the single cycle following the last stop-bit cycle, concurrent with either the next start bit or the return to IDLE.
- `Busy` goes high with the start bit and low in the same cycle as `Tc` when returning to IDLE.
- Counter widths: the baud counter is BRR_W bits and the bit counter is 4 bits. No wrap is permitted within a frame.

## Test plan
- Reset check: hold `Rst_n`=0 with `S_tvalid`=1 -> `Tx`=1, `S_tready`=1, `Level`=0, `Busy`=0, `Tc`=0; no push occurs.
- 8N1 frame: `Brr`=4, `Nbits`=8, `Parity`=00, push 0x55 -> `Tx` sequence 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles (40 cycles total). `Tc` pulses on cycle 41 and `Busy` falls with it.
- Parity and two stop bits: `Brr`=3, `Nbits`=8, push 0x07:
  - even parity -> parity bit 1;
  - odd parity -> parity bit 0;
  - with `Stop2`=1 -> stop high for 6 cycles and frame length 36.
- FIFO full and burst: with `En`=0 push 17 words 0x00..0x10 -> 16 accepted, `S_tready`=0 and `Level`=16. Set `En`=1 -> 16 contiguous frames with no idle between them and 16 `Tc` pulses; `Txe`=1 at the end.
- Clamping and mid-frame config: `Nbits`=3, `Brr`=0, push 0x1FF -> 5 data bits of 1, each 2 cycles. Changing `Nbits` to 8 mid-frame leaves this frame at 5 bits; the next frame uses 8.
- Abort: assert `Rst_n`=0 during DATA with 3 words queued -> `Tx`=1 with no clock edge needed; after release `Level`=0 and `Tx` stays idle.
